// File: rtl/alu_issue_if.sv
// Handshake and datapath bundle between decode, the ALU issue stage, the ALU
// and writeback. The slave view belongs to the issue stage; the master view
// is the surrounding environment (decode, ALU and writeback).
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [4:0]            in_rd;
  logic [DATA_WIDTH-1:0] in_rs1_val;
  logic [DATA_WIDTH-1:0] in_rs2_val;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [2:0]            alu_funct3;
  logic                  alu_funct7;
  logic [DATA_WIDTH-1:0] alu_opa;
  logic [DATA_WIDTH-1:0] alu_opb;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rd,
           in_rs1_val, in_rs2_val, in_imm, in_pc, alu_res, wb_ready,
    output in_ready, alu_funct3, alu_funct7, alu_opa, alu_opb,
           wb_valid, wb_rd, wb_data, illegal
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rd,
           in_rs1_val, in_rs2_val, in_imm, in_pc, alu_res, wb_ready,
    input  in_ready, alu_funct3, alu_funct7, alu_opa, alu_opb,
           wb_valid, wb_rd, wb_data, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-issue stage of the RV32I integer pipe. S1 holds the selected ALU
// operands, the ALU adds one registered cycle, S2 carries the destination tag
// and a one-entry data hold so writeback can stall without losing the result.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rstn,
  alu_issue_if.slave  bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // Encoding check for the instruction classes this stage executes.
  function automatic logic is_legal(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic [6:0] funct7,
                                    input logic [6:0] imm_hi);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          ok = 1'b1;
        end else if (funct7 == 7'b0100000) begin
          ok = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else begin
          ok = 1'b0;
        end
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b001:  ok = (imm_hi == 7'b0000000);
          3'b101:  ok = (imm_hi == 7'b0000000) || (imm_hi == 7'b0100000);
          default: ok = 1'b1;
        endcase
      end
      OPC_LUI:   ok = 1'b1;
      OPC_AUIPC: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic                  advance;
  logic                  retire;
  logic                  accept;
  logic                  in_legal;
  logic                  load;

  logic [DATA_WIDTH-1:0] map_opa;
  logic [DATA_WIDTH-1:0] map_opb;
  logic [2:0]            map_funct3;
  logic                  map_funct7;

  logic                  s1_valid;
  logic [2:0]            s1_funct3;
  logic                  s1_funct7;
  logic [DATA_WIDTH-1:0] s1_opa;
  logic [DATA_WIDTH-1:0] s1_opb;
  logic [4:0]            s1_rd;

  logic                  s2_valid;
  logic [4:0]            s2_rd;
  logic                  fresh;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  illegal_q;

  assign advance  = s1_valid & (~s2_valid | bus.wb_ready);
  assign retire   = s2_valid & bus.wb_ready;
  assign accept   = bus.in_valid & bus.in_ready;
  assign in_legal = is_legal(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_imm[11:5]);
  assign load     = accept & in_legal;

  assign bus.in_ready = ~s1_valid | advance;

  // Select ALU operands and function bits from the incoming instruction.
  always_comb begin
    map_opa    = {DATA_WIDTH{1'b0}};
    map_opb    = {DATA_WIDTH{1'b0}};
    map_funct3 = 3'b000;
    map_funct7 = 1'b0;
    case (bus.in_opcode)
      OPC_OP: begin
        map_opa    = bus.in_rs1_val;
        map_opb    = bus.in_rs2_val;
        map_funct3 = bus.in_funct3;
        map_funct7 = bus.in_funct7[5];
      end
      OPC_OPIMM: begin
        map_opa    = bus.in_rs1_val;
        map_opb    = bus.in_imm;
        map_funct3 = bus.in_funct3;
        map_funct7 = (bus.in_funct3 == 3'b101) ? bus.in_imm[10] : 1'b0;
      end
      OPC_LUI: begin
        map_opb    = bus.in_imm;
      end
      OPC_AUIPC: begin
        map_opa    = bus.in_pc;
        map_opb    = bus.in_imm;
      end
      default: begin
        map_opa    = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // S1 issue register: load on accept, clear on advance, hold while stalled.
  // Fields are zeroed when empty so the ALU sees all-zero inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_funct3 <= 3'b000;
      s1_funct7 <= 1'b0;
      s1_opa    <= {DATA_WIDTH{1'b0}};
      s1_opb    <= {DATA_WIDTH{1'b0}};
      s1_rd     <= 5'd0;
    end else if (load) begin
      s1_valid  <= 1'b1;
      s1_funct3 <= map_funct3;
      s1_funct7 <= map_funct7;
      s1_opa    <= map_opa;
      s1_opb    <= map_opb;
      s1_rd     <= bus.in_rd;
    end else if (advance) begin
      s1_valid  <= 1'b0;
      s1_funct3 <= 3'b000;
      s1_funct7 <= 1'b0;
      s1_opa    <= {DATA_WIDTH{1'b0}};
      s1_opb    <= {DATA_WIDTH{1'b0}};
      s1_rd     <= 5'd0;
    end
  end

  // S2 tag register: takes S1 on advance, empties on a retire with no refill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_rd    <= 5'd0;
      fresh    <= 1'b0;
    end else if (advance) begin
      s2_valid <= 1'b1;
      s2_rd    <= s1_rd;
      fresh    <= 1'b1;
    end else if (retire) begin
      s2_valid <= 1'b0;
      fresh    <= 1'b0;
    end else begin
      fresh    <= 1'b0;
    end
  end

  // Capture the ALU result in its only valid cycle; S1 may refill behind it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_data <= {DATA_WIDTH{1'b0}};
    end else if (fresh) begin
      hold_data <= bus.alu_res;
    end
  end

  // One-cycle flag for an instruction consumed without being issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept & ~in_legal;
    end
  end

  assign bus.alu_funct3 = s1_funct3;
  assign bus.alu_funct7 = s1_funct7;
  assign bus.alu_opa    = s1_opa;
  assign bus.alu_opb    = s1_opb;
  assign bus.wb_valid   = s2_valid;
  assign bus.wb_rd      = s2_rd;
  assign bus.wb_data    = fresh ? bus.alu_res : hold_data;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference model computes each
// instruction's architectural result at accept time; a monitor pops and
// compares on every writeback transfer. The bench also plays the ALU.
module tb_alu_issue_stage;
  localparam int DW = 32;
  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm, pc;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  alu_issue_if #(.DATA_WIDTH(DW)) bus();
  alu_issue_stage #(.DATA_WIDTH(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        lat_check = 1'b0;
  logic [1:0]  ready_mode = 2'd0;
  logic        ready_force = 1'b1;
  logic        rnd_ready = 1'b1;

  assign bus.wb_ready = (ready_mode == 2'd2) ? rnd_ready : ready_force;

  // Architectural legality of an encoding.
  function automatic logic ref_legal(input instr_t i);
    if (i.opcode == OP)
      return (i.f7 == 7'h00) || (i.f7 == 7'h20 && (i.f3 == 3'd0 || i.f3 == 3'd5));
    if (i.opcode == OPIMM) begin
      if (i.f3 == 3'd1) return i.imm[11:5] == 7'h00;
      if (i.f3 == 3'd5) return (i.imm[11:5] == 7'h00) || (i.imm[11:5] == 7'h20);
      return 1'b1;
    end
    return (i.opcode == LUI) || (i.opcode == AUIPC);
  endfunction

  // Architectural result of a legal instruction.
  function automatic logic [31:0] ref_result(input instr_t i);
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        alt;
    if (i.opcode == LUI)   return i.imm;
    if (i.opcode == AUIPC) return i.pc + i.imm;
    a   = i.rs1;
    b   = (i.opcode == OP) ? i.rs2 : i.imm;
    sh  = b[4:0];
    alt = (i.opcode == OP) ? i.f7[5] : i.imm[10];
    case (i.f3)
      3'd0: return (i.opcode == OP && alt) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Behaviour of the downstream ALU as seen on its funct/operand inputs.
  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Registered ALU with one cycle of latency.
  always @(posedge clk) begin
    bus.alu_res <= alu_model(bus.alu_funct3, bus.alu_funct7, bus.alu_opa, bus.alu_opb);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc);
    instr_t i;
    i.opcode = opc; i.f3 = f3; i.f7 = f7; i.rd = rd;
    i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      i;
    logic [11:0] imm12;
    int          k;
    k       = $urandom_range(4);
    imm12   = 12'($urandom);
    i.rd    = 5'($urandom);
    i.rs1   = $urandom;
    i.rs2   = $urandom;
    i.pc    = $urandom & 32'hFFFF_FFFC;
    i.f3    = 3'($urandom);
    i.f7    = 7'($urandom);
    i.opcode = 7'($urandom);
    case (k)
      0: begin
        i.opcode = OP;
        i.f7 = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
        if (i.f7 == 7'h20) i.f3 = ($urandom_range(1) == 1) ? 3'd5 : 3'd0;
      end
      1: begin
        i.opcode = OPIMM;
        if (i.f3 == 3'd1) imm12[11:5] = 7'h00;
        if (i.f3 == 3'd5) imm12[11:5] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
        i.f7 = imm12[11:5];
      end
      2: begin i.opcode = LUI;   i.f3 = 3'd0; end
      3: begin i.opcode = AUIPC; i.f3 = 3'd0; end
      default: begin
        case ($urandom_range(4))
          0: i.opcode = OP;
          1: i.opcode = OPIMM;
          2: i.opcode = LUI;
          3: i.opcode = AUIPC;
          default: i.opcode = 7'($urandom);
        endcase
      end
    endcase
    i.imm = {{20{imm12[11]}}, imm12};
    if (k == 2 || k == 3) i.imm = $urandom & 32'hFFFF_F000;
    return i;
  endfunction

  // Monitor and scoreboard: observes both handshakes half a cycle before the edge.
  initial begin
    exp_t        e;
    instr_t      cur;
    logic        exp_ill;
    logic        prev_stall;
    logic [4:0]  prev_rd;
    logic [31:0] prev_data;
    exp_ill = 1'b0; prev_stall = 1'b0; prev_rd = 5'd0; prev_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sb_q.delete();
        exp_ill = 1'b0;
        prev_stall = 1'b0;
      end else begin
        cyc++;
        check("illegal_pulse", {31'd0, bus.illegal}, {31'd0, exp_ill});
        if (prev_stall) begin
          check("stall_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
          check("stall_wb_rd", {27'd0, bus.wb_rd}, {27'd0, prev_rd});
          check("stall_wb_data", bus.wb_data, prev_data);
        end
        if (bus.wb_valid && bus.wb_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_wb: got rd=%0d data=%h, expected no writeback", bus.wb_rd, bus.wb_data);
          end else begin
            e = sb_q.pop_front();
            check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
            check("wb_data", bus.wb_data, e.data);
            if (lat_check) check("latency", 32'(cyc - e.cyc), 32'd2);
          end
        end
        if (lat_check) check("in_ready_b2b", {31'd0, bus.in_ready}, 32'd1);
        prev_stall = bus.wb_valid & ~bus.wb_ready;
        prev_rd    = bus.wb_rd;
        prev_data  = bus.wb_data;
        exp_ill    = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
          cur = mk(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rd,
                   bus.in_rs1_val, bus.in_rs2_val, bus.in_imm, bus.in_pc);
          if (ref_legal(cur)) begin
            e.rd = cur.rd; e.data = ref_result(cur); e.cyc = cyc;
            sb_q.push_back(e);
          end else begin
            exp_ill = 1'b1;
          end
        end
      end
    end
  end

  // Random writeback backpressure pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(3) != 0);
    end
  end

  task automatic drive(input instr_t i);
    bus.in_opcode = i.opcode; bus.in_funct3 = i.f3; bus.in_funct7 = i.f7; bus.in_rd = i.rd;
    bus.in_rs1_val = i.rs1; bus.in_rs2_val = i.rs2; bus.in_imm = i.imm; bus.in_pc = i.pc;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (bus.in_ready) return;
    end
    n_vec++; n_err++;
    $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected acceptance");
  endtask

  task automatic send(input instr_t i);
    @(posedge clk);
    #1;
    drive(i);
    wait_accept();
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 500; w++) begin
      if (sb_q.size() == 0 && !bus.wb_valid) break;
      @(negedge clk);
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(mk(7'd0, 3'd0, 7'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0));
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("rst_alu_opa", bus.alu_opa, 32'd0);
    check("rst_alu_opb", bus.alu_opb, 32'd0);
    check("rst_alu_f3", {29'd0, bus.alu_funct3}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Directed results and two-cycle latency, then four back-to-back ADDIs.
    lat_check = 1'b1;
    send(mk(OP,    3'd0, 7'h00, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0));
    send(mk(OP,    3'd0, 7'h20, 5'd4, 32'd5, 32'd7, 32'd0, 32'd0));
    send(mk(OPIMM, 3'd5, 7'h20, 5'd5, 32'h8000_0000, 32'd0, 32'h404, 32'd0));
    send(mk(AUIPC, 3'd0, 7'h00, 5'd6, 32'd0, 32'd0, 32'h1000, 32'h100));
    idle();
    drain();
    for (int k = 0; k < 4; k++)
      send(mk(OPIMM, 3'd0, 7'h00, 5'(k + 8), 32'(k * 100), 32'd0, 32'(k + 1), 32'd0));
    idle();
    drain();
    lat_check = 1'b0;

    // Backpressure: S1+S2 fill, third instruction waits, all drain in order.
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    send(mk(OP,    3'd4, 7'h00, 5'd10, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'd0));
    send(mk(OP,    3'd2, 7'h00, 5'd11, 32'hFFFF_FFF0, 32'd3, 32'd0, 32'd0));
    @(posedge clk);
    #1;
    drive(mk(OPIMM, 3'd6, 7'h00, 5'd12, 32'h1200_0000, 32'd0, 32'hFFFF_F800, 32'd0));
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    wait_accept();
    idle();
    drain();

    // Illegal OP funct7, followed by a legal instruction.
    send(mk(OP, 3'd0, 7'h01, 5'd13, 32'd1, 32'd2, 32'd0, 32'd0));
    send(mk(OP, 3'd1, 7'h00, 5'd0, 32'h0000_0003, 32'd4, 32'd0, 32'd0));
    idle();
    drain();

    // Randomised traffic with random backpressure and idle gaps.
    ready_mode = 2'd2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(4) == 0) idle();
      send(rand_instr());
    end
    idle();
    @(posedge clk);
    #1;
    ready_mode = 2'd0;
    ready_force = 1'b1;
    drain();

    // Reset with S1 and S2 both occupied.
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    send(mk(OP, 3'd7, 7'h00, 5'd20, 32'hFFFF_0000, 32'h00FF_FF00, 32'd0, 32'd0));
    send(mk(OP, 3'd6, 7'h00, 5'd21, 32'h0000_00F0, 32'h0000_000F, 32'd0, 32'd0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("pre_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_alu_opa", bus.alu_opa, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    ready_force = 1'b1;
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    send(mk(LUI, 3'd0, 7'h00, 5'd22, 32'd0, 32'd0, 32'hABCD_E000, 32'd0));
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
